mem_req_arbiter: RTL and testbench

Parametrised successor to the two-cache memory controller. Arbitrates between NUM_CH cache-side request channels (channel 0 = instruction cache, channel 1 = data cache, further channels optional) and issues their requests to one shared backing-memory port. Reads are cache-line refill bursts; writes are single-word write-through. Responses are routed back to the owning channel. One transaction is in flight at a time.

---
 rtl/mem_req_arbiter_pkg.sv | 21 ++
 rtl/mem_req_arbiter_if.sv | 38 +++
 rtl/mem_req_arbiter_rr.sv | 29 ++
 rtl/mem_req_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and size helpers for the memory request arbiter.
package mem_sys_pkg;

    // Transaction controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2
    } state_t;

    // Bytes in one data word.
    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

    // Bytes in one cache line refill.
    function automatic int line_bytes(input int data_w, input int burst_len);
        return (data_w / 8) * burst_len;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Cache-side request/response channels plus the shared backing-memory port.
interface mem_req_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_we;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_last;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_rsp_valid;
    logic [DATA_W-1:0]        mem_rdata;

    // Arbiter side: accepts cache requests, drives memory commands.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_last,
        output mem_req_valid, mem_we, mem_addr, mem_wdata
    );

    // Environment side: caches plus backing memory.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_last,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_req_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_valid
);
    int w_idx;

    // Walk the channels starting at the pointer and keep the first hit.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_valid   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_idx]) begin
                o_valid      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = IW'(w_idx);
            end
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between cache channels.
// One transaction in flight: line refill bursts for reads, single-word writes.
module mem_req_arbiter
    import mem_sys_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_req_arbiter_if.slave  bus,
    output logic              o_err_stray
);
    localparam int IW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW         = $clog2(BURST_LEN + 1);
    localparam int WORD_BYTES = word_bytes(DATA_W);
    localparam int LINE_BYTES = line_bytes(DATA_W, BURST_LEN);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    state_t              r_state;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_owner;
    logic [CW-1:0]       r_issue_cnt;
    logic [CW-1:0]       r_rsp_cnt;
    logic [NUM_CH-1:0]   r_req_ready;
    logic [NUM_CH-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_last;
    logic                r_mem_req_valid;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_err_stray;

    logic [NUM_CH-1:0]   w_gnt;
    logic [IW-1:0]       w_gnt_idx;
    logic                w_gnt_valid;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_handshake;
    logic                w_issue_last;
    logic                w_rsp_last;

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .i_req     (bus.req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_valid   (w_gnt_valid)
    );

    assign w_req_addr   = bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_handshake  = r_mem_req_valid & bus.mem_req_ready;
    // A write is a single beat; a read finishes on its BURST_LEN-th beat.
    assign w_issue_last = r_mem_we || (r_issue_cnt == CW'(BURST_LEN - 1));
    assign w_rsp_last   = r_mem_we || (r_rsp_cnt == CW'(BURST_LEN - 1));

    // Grant, command issue and response routing state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_rr_ptr        <= '0;
            r_owner         <= '0;
            r_issue_cnt     <= '0;
            r_rsp_cnt       <= '0;
            r_req_ready     <= '0;
            r_rsp_valid     <= '0;
            r_rsp_data      <= '0;
            r_rsp_last      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_err_stray     <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_last  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Nothing is outstanding, so any memory response is stray.
                    if (bus.mem_rsp_valid) begin
                        r_err_stray <= 1'b1;
                    end
                    if (w_gnt_valid) begin
                        r_req_ready     <= w_gnt;
                        r_owner         <= w_gnt_idx;
                        r_mem_we        <= bus.req_we[w_gnt_idx];
                        r_mem_addr      <= bus.req_we[w_gnt_idx] ? (w_req_addr & WORD_MASK)
                                                                 : (w_req_addr & LINE_MASK);
                        r_mem_wdata     <= bus.req_wdata[w_gnt_idx*DATA_W +: DATA_W];
                        r_mem_req_valid <= 1'b1;
                        r_issue_cnt     <= '0;
                        r_rsp_cnt       <= '0;
                        r_rr_ptr        <= (w_gnt_idx == IW'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE, COLLECT: begin
                    if (w_handshake) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(WORD_BYTES);
                        if (w_issue_last) begin
                            r_mem_req_valid <= 1'b0;
                            r_state         <= COLLECT;
                        end
                    end
                    // Responses may already be returning while later beats issue.
                    if (bus.mem_rsp_valid) begin
                        r_rsp_cnt   <= r_rsp_cnt + 1'b1;
                        r_rsp_valid <= NUM_CH'(1) << r_owner;
                        r_rsp_data  <= bus.mem_rdata;
                        if (w_rsp_last) begin
                            r_rsp_last      <= 1'b1;
                            r_mem_req_valid <= 1'b0;
                            r_state         <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_last      = r_rsp_last;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign o_err_stray       = r_err_stray;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed transactions, a backing-memory model
// with latency 2, and a scoreboard of expected grants, commands and responses.
module tb_mem_req_arbiter;
    import mem_sys_pkg::*;

    localparam int NUM_CH    = 3;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;
    localparam logic [31:0] ACK_DATA = 32'h5A5A0ACC;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { logic [31:0] data; logic last; int ch; } rsp_t;
    typedef struct { int due; logic [31:0] data; } pend_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_stray;

    mem_req_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_req_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_err_stray (err_stray)
    );

    always #5 clk = ~clk;

    txn_t  chq [NUM_CH][$];
    int    exp_gnt[$];
    txn_t  exp_cmd[$];
    rsp_t  exp_rsp[$];
    pend_t pend[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    stray_req = 0;
    int    stall_req = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {16'hCAFE, a[15:0]};
    endfunction

    // Scoreboard entries for one transaction, given the hand-aligned address.
    task automatic expect_txn(input int ch, input logic we, input logic [31:0] aaddr,
                              input logic [31:0] wdata);
        int beats;
        beats = we ? 1 : BURST_LEN;
        exp_gnt.push_back(ch);
        for (int i = 0; i < beats; i++) begin
            exp_cmd.push_back('{we, aaddr + 32'(4 * i), wdata});
            exp_rsp.push_back('{we ? ACK_DATA : mem_f(aaddr + 32'(4 * i)), (i == beats - 1), ch});
        end
    endtask

    task automatic submit(input int ch, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        chq[ch].push_back('{we, addr, wdata});
    endtask

    // One cycle of cache-side driving: retire granted requests, present the next.
    task automatic step();
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.req_ready[c] && chq[c].size() > 0) chq[c].delete(0);
            if (chq[c].size() > 0) begin
                bus.req_valid[c] = 1'b1;
                bus.req_we[c]    = chq[c][0].we;
                bus.req_addr[c*ADDR_W +: ADDR_W]  = chq[c][0].addr;
                bus.req_wdata[c*DATA_W +: DATA_W] = chq[c][0].wdata;
            end else begin
                bus.req_valid[c] = 1'b0;
            end
        end
    endtask

    function automatic bit work_left();
        bit b;
        b = (exp_gnt.size() > 0) || (exp_rsp.size() > 0);
        for (int c = 0; c < NUM_CH; c++) if (chq[c].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (work_left() && n < budget);
        check({name, " completes"}, 64'(work_left()), 64'(0));
        step();
    endtask

    // Monitor and backing-memory model, sampled on the falling edge.
    initial begin
        int cyc, g, stall_left, hs_cnt, stall_done, stray_done;
        bit prev_wait, rsp_due;
        logic [31:0] prev_addr;
        txn_t  c;
        rsp_t  r;
        pend_t p;
        cyc = 0; stall_left = 0; hs_cnt = 0; stall_done = 0; stray_done = 0;
        prev_wait = 1'b0; rsp_due = 1'b0; prev_addr = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != '0) begin
                if (exp_gnt.size() == 0) check("unexpected grant", 64'(bus.req_ready), 64'(0));
                else begin
                    g = exp_gnt.pop_front();
                    check("grant one-hot", 64'(bus.req_ready), 64'(1) << g);
                    check("mem_req_valid with grant", 64'(bus.mem_req_valid), 64'(1));
                end
            end
            if (rsp_due && !reset) check("rsp one cycle after mem rsp", 64'(bus.rsp_valid != '0), 64'(1));
            if (bus.rsp_valid != '0) begin
                if (exp_rsp.size() == 0) check("unexpected rsp_valid", 64'(bus.rsp_valid), 64'(0));
                else begin
                    r = exp_rsp.pop_front();
                    check("rsp_valid owner", 64'(bus.rsp_valid), 64'(1) << r.ch);
                    check("rsp_data", 64'(bus.rsp_data), 64'(r.data));
                    check("rsp_last", 64'(bus.rsp_last), 64'(r.last));
                end
            end
            if (prev_wait) begin
                check("stalled valid held", 64'(bus.mem_req_valid), 64'(1));
                check("stalled addr held", 64'(bus.mem_addr), 64'(prev_addr));
            end
            if (stall_left > 0) begin
                bus.mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                bus.mem_req_ready = 1'b1;
            end
            prev_wait = bus.mem_req_valid && !bus.mem_req_ready;
            prev_addr = bus.mem_addr;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (exp_cmd.size() == 0) check("unexpected mem command", 64'(bus.mem_addr), 64'(0));
                else begin
                    c = exp_cmd.pop_front();
                    check("mem_we", 64'(bus.mem_we), 64'(c.we));
                    check("mem_addr", 64'(bus.mem_addr), 64'(c.addr));
                    if (c.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(c.wdata));
                end
                pend.push_back('{cyc + 2, bus.mem_we ? ACK_DATA : mem_f(bus.mem_addr)});
                if (stall_req > stall_done) begin
                    hs_cnt++;
                    if (hs_cnt == 2) begin
                        stall_left = 5;
                        hs_cnt = 0;
                        stall_done++;
                    end
                end
            end
            bus.mem_rsp_valid = 1'b0;
            rsp_due = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rdata     = p.data;
                rsp_due = (exp_rsp.size() > 0);
            end else if (stray_req > stray_done) begin
                stray_done++;
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rdata     = 32'hBAD0BAD0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset req_ready", 64'(bus.req_ready), 64'(0));
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset rsp_data", 64'(bus.rsp_data), 64'(0));
        check("reset rsp_last", 64'(bus.rsp_last), 64'(0));
        check("reset mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
        check("reset mem_we", 64'(bus.mem_we), 64'(0));
        check("reset mem_addr", 64'(bus.mem_addr), 64'(0));
        check("reset mem_wdata", 64'(bus.mem_wdata), 64'(0));
        check("reset err_stray", 64'(err_stray), 64'(0));
        reset = 1'b0;
        repeat (2) step();
        check("idle mem_req_valid", 64'(bus.mem_req_valid), 64'(0));

        // Line refill from ch0: 0x104 aligns to line 0x100.
        expect_txn(0, 1'b0, 32'h100, 32'h0);
        submit(0, 1'b0, 32'h104, 32'h11111111);
        run_done("read ch0", 100);

        // Write-through from ch1: 0x203 aligns to word 0x200.
        expect_txn(1, 1'b1, 32'h200, 32'hDEADBEEF);
        submit(1, 1'b1, 32'h203, 32'hDEADBEEF);
        run_done("write ch1", 100);

        // ch0 and ch1 both pending; pointer sits at 2, so order is 0,1,0,1.
        expect_txn(0, 1'b1, 32'h300, 32'hA0A0A0A0);
        expect_txn(1, 1'b1, 32'h310, 32'hB0B0B0B0);
        expect_txn(0, 1'b1, 32'h304, 32'hA1A1A1A1);
        expect_txn(1, 1'b1, 32'h314, 32'hB1B1B1B1);
        submit(0, 1'b1, 32'h300, 32'hA0A0A0A0);
        submit(0, 1'b1, 32'h306, 32'hA1A1A1A1);
        submit(1, 1'b1, 32'h311, 32'hB0B0B0B0);
        submit(1, 1'b1, 32'h314, 32'hB1B1B1B1);
        run_done("alternating ch0/ch1", 200);

        // Refill with memory ready dropped for 5 cycles after the second beat.
        stall_req++;
        expect_txn(0, 1'b0, 32'h400, 32'h0);
        submit(0, 1'b0, 32'h40C, 32'h0);
        run_done("stalled read", 100);

        // Stray memory response while idle.
        repeat (3) step();
        check("err_stray before stray", 64'(err_stray), 64'(0));
        stray_req++;
        repeat (4) step();
        check("err_stray after stray", 64'(err_stray), 64'(1));

        // Reset in the middle of a refill from ch2.
        expect_txn(2, 1'b0, 32'h800, 32'h0);
        submit(2, 1'b0, 32'h804, 32'h0);
        n = 0;
        do begin
            step();
            n++;
        end while (chq[2].size() > 0 && n < 50);
        check("mid-burst grant seen", 64'(chq[2].size()), 64'(0));
        repeat (2) step();
        #2 reset = 1'b1;
        #1;
        check("abort mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
        check("abort mem_addr", 64'(bus.mem_addr), 64'(0));
        check("abort rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("abort rsp_data", 64'(bus.rsp_data), 64'(0));
        check("abort rsp_last", 64'(bus.rsp_last), 64'(0));
        check("abort state", 64'(dut.r_state), 64'(IDLE));
        check("abort rr_ptr", 64'(dut.r_rr_ptr), 64'(0));
        exp_gnt.delete();
        exp_cmd.delete();
        exp_rsp.delete();
        repeat (2) step();
        reset = 1'b0;
        n = 0;
        while (pend.size() > 0 && n < 20) begin
            step();
            n++;
        end
        repeat (3) step();

        // All three channels pending after reset: order 0,1,2,0.
        expect_txn(0, 1'b1, 32'h500, 32'hD0D0D0D0);
        expect_txn(1, 1'b1, 32'h600, 32'hD1D1D1D1);
        expect_txn(2, 1'b1, 32'h708, 32'hD2D2D2D2);
        expect_txn(0, 1'b1, 32'h504, 32'hD3D3D3D3);
        submit(0, 1'b1, 32'h501, 32'hD0D0D0D0);
        submit(0, 1'b1, 32'h507, 32'hD3D3D3D3);
        submit(1, 1'b1, 32'h603, 32'hD1D1D1D1);
        submit(2, 1'b1, 32'h70A, 32'hD2D2D2D2);
        run_done("three-way round robin", 200);

        repeat (4) step();
        check("leftover grants", 64'(exp_gnt.size()), 64'(0));
        check("leftover commands", 64'(exp_cmd.size()), 64'(0));
        check("leftover responses", 64'(exp_rsp.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
